sdio_resp_rx: RTL and testbench

Receives the 48-bit response token a card drives on the SDIO CMD line after the host command framer releases the line.
- Sits directly downstream of the command framer: armed when the framer's last command bit (end bit) has been driven.
- Hunts for the start bit, with a timeout.
- Shifts the token in one bit per SD-clock rising edge and checks the CRC7 and framing bits.
- Presents the index, argument and error flags to the controller FSM and the UART debug path.

---
 rtl/sdio_pkg.sv | 29 ++
 rtl/sdio_crc7.sv | 29 ++
 rtl/sdio_resp_rx.sv | 160 ++++++++++++++++
 tb/tb_sdio_resp_rx.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/sdio_pkg.sv
// Shared definitions for the SDIO response receiver and command framer:
// state encoding, token geometry and the CRC7 serial step.
package sdio_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_START,
    RECEIVE,
    DONE
  } resp_state_e;

  localparam int RESP_BITS = 48;
  localparam logic [6:0] CRC7_POLY = 7'h09;

  localparam int TRANS_BIT = 46;
  localparam int IDX_MSB   = 45;
  localparam int IDX_LSB   = 40;
  localparam int ARG_MSB   = 39;
  localparam int ARG_LSB   = 8;
  localparam int CRC_MSB   = 7;
  localparam int CRC_LSB   = 1;
  localparam int END_BIT   = 0;

  // One MSB-first step of x^7+x^3+1.
  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
    crc7_step = {crc[5:0], 1'b0} ^ (((crc[6] ^ din) == 1'b1) ? CRC7_POLY : 7'h00);
  endfunction

endpackage

// File: rtl/sdio_crc7.sv
// Serial CRC7 engine; clr takes effect before a simultaneous en step,
// so clr+en starts a fresh CRC with din as its first bit.
module sdio_crc7
  import sdio_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic       din,
  output logic [6:0] crc
);

  logic [6:0] crc_q, crc_d;
  logic [6:0] base;

  always_comb begin
    base  = clr ? 7'h00 : crc_q;
    crc_d = en ? crc7_step(base, din) : base;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) crc_q <= 7'h00;
    else     crc_q <= crc_d;
  end

  assign crc = crc_q;

endmodule

// File: rtl/sdio_resp_rx.sv
// Receives the 48-bit response token from the card on CMD, with a start-bit
// hunt timeout, CRC7 check and framing-bit checks.
module sdio_resp_rx
  import sdio_pkg::*;
#(
  parameter int NCR_MAX = 64,
  parameter int CNT_W   = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sample_en,
  input  logic        cmd_in,
  input  logic        start,
  input  logic        check_crc,
  output logic        busy,
  output logic        resp_valid,
  output logic [5:0]  resp_index,
  output logic [31:0] resp_arg,
  output logic [6:0]  resp_crc,
  output logic        err_timeout,
  output logic        err_crc,
  output logic        err_trans,
  output logic        err_end
);

  resp_state_e state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d, wait_inc;
  logic [5:0] bit_cnt_q, bit_cnt_d;
  logic [RESP_BITS-3:0] shift_q, shift_d;
  logic [RESP_BITS-2:0] word;
  logic check_q, check_d;
  logic [5:0] index_q, index_d;
  logic [31:0] arg_q, arg_d;
  logic [6:0] rcrc_q, rcrc_d;
  logic to_q, to_d, ecrc_q, ecrc_d, etrans_q, etrans_d, eend_q, eend_d;
  logic crc_clr, crc_en;
  logic [6:0] crc_val;

  sdio_crc7 u_crc (
    .clk (clk),
    .rst (rst),
    .clr (crc_clr),
    .en  (crc_en),
    .din (cmd_in),
    .crc (crc_val)
  );

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    check_d    = check_q;
    index_d    = index_q;
    arg_d      = arg_q;
    rcrc_d     = rcrc_q;
    to_d       = to_q;
    ecrc_d     = ecrc_q;
    etrans_d   = etrans_q;
    eend_d     = eend_q;
    crc_clr    = 1'b0;
    crc_en     = 1'b0;
    wait_inc   = wait_cnt_q + CNT_W'(1);
    word       = {shift_q, cmd_in};

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = WAIT_START;
          wait_cnt_d = '0;
          check_d    = check_crc;
          index_d    = '0;
          arg_d      = '0;
          rcrc_d     = '0;
          to_d       = 1'b0;
          ecrc_d     = 1'b0;
          etrans_d   = 1'b0;
          eend_d     = 1'b0;
        end
      end
      WAIT_START: begin
        // A start bit on the final allowed sample beats the timeout.
        if (sample_en) begin
          if (!cmd_in) begin
            state_d   = RECEIVE;
            bit_cnt_d = 6'd46;
            crc_clr   = 1'b1;
            crc_en    = 1'b1;
          end else begin
            wait_cnt_d = wait_inc;
            if (wait_inc == CNT_W'(NCR_MAX)) begin
              to_d    = 1'b1;
              state_d = DONE;
            end
          end
        end
      end
      RECEIVE: begin
        if (sample_en) begin
          shift_d   = word[RESP_BITS-3:0];
          bit_cnt_d = bit_cnt_q - 6'd1;
          crc_en    = (bit_cnt_q >= 6'd8);
          // Bit 0 just arrived: the CRC finished eight samples ago.
          if (bit_cnt_q == 6'd0) begin
            index_d  = word[IDX_MSB:IDX_LSB];
            arg_d    = word[ARG_MSB:ARG_LSB];
            rcrc_d   = word[CRC_MSB:CRC_LSB];
            etrans_d = word[TRANS_BIT];
            eend_d   = ~word[END_BIT];
            ecrc_d   = check_q & (crc_val != word[CRC_MSB:CRC_LSB]);
            state_d  = DONE;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      check_q    <= 1'b0;
      index_q    <= '0;
      arg_q      <= '0;
      rcrc_q     <= '0;
      to_q       <= 1'b0;
      ecrc_q     <= 1'b0;
      etrans_q   <= 1'b0;
      eend_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      check_q    <= check_d;
      index_q    <= index_d;
      arg_q      <= arg_d;
      rcrc_q     <= rcrc_d;
      to_q       <= to_d;
      ecrc_q     <= ecrc_d;
      etrans_q   <= etrans_d;
      eend_q     <= eend_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign resp_valid  = (state_q == DONE);
  assign resp_index  = index_q;
  assign resp_arg    = arg_q;
  assign resp_crc    = rcrc_q;
  assign err_timeout = to_q;
  assign err_crc     = ecrc_q;
  assign err_trans   = etrans_q;
  assign err_end     = eend_q;

endmodule

// File: tb/tb_sdio_resp_rx.sv
// Self-checking bench for sdio_resp_rx: a transaction-level model predicts
// every output each cycle, plus literal expectations for the directed tokens.
module tb_sdio_resp_rx;

  localparam int NCR = 64;

  logic clk = 1'b0;
  logic rst, sample_en, cmd_in, start, check_crc;
  logic busy, resp_valid, err_timeout, err_crc, err_trans, err_end;
  logic [5:0] resp_index;
  logic [31:0] resp_arg;
  logic [6:0] resp_crc;

  int checks = 0;
  int failures = 0;
  int cmp_fail_prints = 0;
  logic cmp_en = 1'b0;

  sdio_resp_rx #(.NCR_MAX(NCR), .CNT_W(7)) dut (
    .clk (clk), .rst (rst), .sample_en (sample_en), .cmd_in (cmd_in),
    .start (start), .check_crc (check_crc), .busy (busy), .resp_valid (resp_valid),
    .resp_index (resp_index), .resp_arg (resp_arg), .resp_crc (resp_crc),
    .err_timeout (err_timeout), .err_crc (err_crc), .err_trans (err_trans),
    .err_end (err_end)
  );

  always #5 clk = ~clk;

  // CRC7 as the remainder of msg * x^7 divided by x^7+x^3+1 (0x89).
  function automatic logic [6:0] crcRef(input logic [39:0] msg);
    logic [46:0] r;
    r = {msg, 7'b0};
    for (int i = 46; i >= 7; i--)
      if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
    return r[6:0];
  endfunction

  // Transaction-level model of the receiver.
  logic m_busy = 1'b0, m_valid = 1'b0, m_hunt = 1'b0, m_check = 1'b0;
  int m_waits = 0, m_nbits = 0;
  logic [47:0] m_tok = '0;
  logic [5:0] e_index = '0;
  logic [31:0] e_arg = '0;
  logic [6:0] e_crc = '0;
  logic e_to = 1'b0, e_ecrc = 1'b0, e_trans = 1'b0, e_end = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 0; m_valid = 0; m_hunt = 0; m_check = 0; m_waits = 0; m_nbits = 0;
      e_index = 0; e_arg = 0; e_crc = 0; e_to = 0; e_ecrc = 0; e_trans = 0; e_end = 0;
    end else if (m_valid) begin
      m_valid = 0;
      m_busy = 0;
    end else if (!m_busy) begin
      if (start) begin
        m_busy = 1; m_hunt = 1; m_waits = 0; m_check = check_crc;
        e_index = 0; e_arg = 0; e_crc = 0; e_to = 0; e_ecrc = 0; e_trans = 0; e_end = 0;
      end
    end else if (sample_en) begin
      if (m_hunt) begin
        if (cmd_in == 1'b0) begin
          m_hunt = 0; m_tok = 48'h0; m_nbits = 1;
        end else begin
          m_waits++;
          if (m_waits == NCR) begin e_to = 1; m_valid = 1; end
        end
      end else begin
        m_tok = {m_tok[46:0], cmd_in};
        m_nbits++;
        if (m_nbits == 48) begin
          e_index = m_tok[45:40];
          e_arg   = m_tok[39:8];
          e_crc   = m_tok[7:1];
          e_trans = m_tok[46];
          e_end   = ~m_tok[0];
          e_ecrc  = m_check && (crcRef(m_tok[47:8]) != m_tok[7:1]);
          m_valid = 1;
        end
      end
    end
  end

  // Per-cycle compare of every output against the model.
  always @(posedge clk) begin
    logic [50:0] act, exp;
    #2;
    if (cmp_en) begin
      act = {busy, resp_valid, resp_index, resp_arg, resp_crc, err_timeout, err_crc, err_trans, err_end};
      exp = {m_busy, m_valid, e_index, e_arg, e_crc, e_to, e_ecrc, e_trans, e_end};
      checks++;
      if (act !== exp) begin
        failures++;
        if (cmp_fail_prints < 10) begin
          cmp_fail_prints++;
          $display("[TB] FAIL cycle_model t=%0t got=%h expected=%h", $time, act, exp);
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic se, input logic c);
    @(negedge clk);
    start = s;
    sample_en = se;
    cmd_in = c;
  endtask

  task automatic sendBit(input logic b, input logic hold);
    applyStimulus(1'b0, 1'b1, b);
    if (hold) repeat (3) applyStimulus(1'b0, 1'b0, b);
  endtask

  task automatic sendToken(input logic [47:0] tok, input int idle, input logic chk,
                           input logic sample_on_start, input logic mid_start);
    check_crc = chk;
    applyStimulus(1'b1, sample_on_start, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < idle; i++) sendBit(1'b1, 1'b1);
    for (int i = 47; i >= 0; i--) begin
      if (mid_start && i == 30) applyStimulus(1'b1, 1'b0, tok[i]);
      sendBit(tok[i], i != 0);
    end
  endtask

  task automatic waitValid(input string name);
    int lat = -1;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1);
      if (resp_valid === 1'b1) begin lat = i; break; end
    end
    checkOutput({name, "_latency"}, 64'(lat), 64'd0);
  endtask

  task automatic checkResp(input string name, input logic [5:0] idx, input logic [31:0] arg,
                           input logic [6:0] crc, input logic [3:0] errs);
    checkOutput({name, "_index"}, 64'(resp_index), 64'(idx));
    checkOutput({name, "_arg"}, 64'(resp_arg), 64'(arg));
    checkOutput({name, "_crc"}, 64'(resp_crc), 64'(crc));
    checkOutput({name, "_errs"}, 64'({err_timeout, err_crc, err_trans, err_end}), 64'(errs));
  endtask

  initial begin
    int seen;
    rst = 1'b1; start = 0; sample_en = 0; cmd_in = 1; check_crc = 0;
    cmp_en = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset_busy_valid", 64'({busy, resp_valid}), 64'd0);
    checkResp("reset", 6'h00, 32'h0, 7'h00, 4'b0000);
    rst = 1'b0;

    checkOutput("model_crc_r7", 64'(crcRef(40'h08000001AA)), 64'h09);
    checkOutput("model_crc_cmd0", 64'(crcRef(40'h4000000000)), 64'h4A);

    $display("[TB] R7 token, start with coincident sample");
    sendToken(48'h08_000001AA_13, 3, 1'b1, 1'b1, 1'b0);
    waitValid("r7");
    checkResp("r7", 6'h08, 32'h000001AA, 7'h09, 4'b0000);

    sendToken(48'h3F_90FF8000_FF, 1, 1'b0, 1'b0, 1'b0);
    waitValid("r4");
    checkResp("r4", 6'h3F, 32'h90FF8000, 7'h7F, 4'b0000);

    sendToken(48'h40_00000000_95, 2, 1'b1, 1'b0, 1'b0);
    waitValid("host");
    checkResp("host", 6'h00, 32'h0, 7'h4A, 4'b0010);

    sendToken(48'h08_000001AB_13, 0, 1'b1, 1'b0, 1'b0);
    waitValid("badcrc");
    checkResp("badcrc", 6'h08, 32'h000001AB, 7'h09, 4'b0100);

    sendToken(48'h08_000001AA_12, 2, 1'b1, 1'b0, 1'b0);
    waitValid("badend");
    checkResp("badend", 6'h08, 32'h000001AA, 7'h09, 4'b0001);

    $display("[TB] timeout with CMD held high");
    check_crc = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < NCR; i++) sendBit(1'b1, i != NCR - 1);
    waitValid("timeout");
    checkResp("timeout", 6'h00, 32'h0, 7'h00, 4'b1000);

    sendToken(48'h08_000001AA_13, NCR - 1, 1'b1, 1'b0, 1'b0);
    waitValid("last_sample_start");
    checkResp("last_sample_start", 6'h08, 32'h000001AA, 7'h09, 4'b0000);

    $display("[TB] reset in the middle of a token");
    check_crc = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    for (int i = 47; i >= 28; i--) sendBit(1'b0, 1'b1);
    checkOutput("pre_rst_busy", 64'(busy), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("rst_busy_valid", 64'({busy, resp_valid}), 64'd0);
    checkResp("rst", 6'h00, 32'h0, 7'h00, 4'b0000);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 120; i++) begin
      applyStimulus(1'b0, (i % 4) == 0, 1'b0);
      if (resp_valid === 1'b1 || busy === 1'b1) seen++;
    end
    checkOutput("rst_no_activity", 64'(seen), 64'd0);

    sendToken(48'h08_000001AA_13, 2, 1'b1, 1'b0, 1'b1);
    waitValid("after_rst");
    checkResp("after_rst", 6'h08, 32'h000001AA, 7'h09, 4'b0000);

    repeat (4) applyStimulus(1'b0, 1'b0, 1'b1);
    checkResp("hold", 6'h08, 32'h000001AA, 7'h09, 4'b0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
